pipe_stage_hs: RTL and testbench

//  Generic parametrised pipeline stage register (IF/ID, ID/EX, EX/MEM, MEM/WB) with valid/ready handshake,

---
 rtl/pipe_stage_hs.sv | 78 +++++++
 tb/tb_pipe_stage_hs.sv | 114 +++++++++++
 2 files changed

// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: parametrised pipeline stage register with valid/ready handshake, rdy freeze, flush, optional skid
// Build option: define PIPE_SKID_EN for the 2-entry skid variant (registered in_ready); default is single entry.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   rdy                  global enable, 0 freezes all state
//   flush                kill held and incoming entries
//   in_valid/in_ready    upstream handshake, in_data payload
//   out_valid/out_ready  downstream handshake, out_data registered payload
//   occ                  entries held (0..1, or 0..2 with skid)
module pipe_stage_hs #(
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] RST_DATA = '0,
  parameter bit FLUSH_CLR = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t r_state, w_state_nxt;
  logic [DATA_W-1:0] r_data, r_skid;
  logic w_out_valid, w_accept, w_emit;
  assign w_out_valid = r_state != EMPTY;
  assign out_valid = w_out_valid;
  assign out_data = r_data;
  // State encoding doubles as the occupancy count.
  assign occ = r_state;
`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
  // Depends only on state, so no combinational path from out_ready.
  assign in_ready = rdy & ~rst & ~flush & (r_state != TWO);
`else
  localparam bit SKID = 1'b0;
  assign in_ready = rdy & ~rst & ~flush & (~w_out_valid | out_ready);
`endif
  assign w_accept = in_valid & in_ready;
  assign w_emit = rdy & w_out_valid & out_ready;
  always_comb begin
    w_state_nxt = r_state;
    if (flush)
      w_state_nxt = EMPTY;
    else if (r_state == TWO)
      w_state_nxt = w_emit ? ONE : TWO;
    else if (w_accept)
      w_state_nxt = (SKID && w_out_valid && !w_emit) ? TWO : ONE;
    else if (w_emit)
      w_state_nxt = EMPTY;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_data  <= RST_DATA;
      r_skid  <= RST_DATA;
    end else if (rdy) begin
      r_state <= w_state_nxt;
      if (flush) begin
        if (FLUSH_CLR) begin
          r_data <= RST_DATA;
          r_skid <= RST_DATA;
        end
      end else if (r_state == TWO) begin
        if (w_emit) r_data <= r_skid;
      end else if (w_accept) begin
        // Out register stalled: park the newer payload in the skid entry.
        if (SKID && w_out_valid && !w_emit) r_skid <= in_data;
        else r_data <= in_data;
      end
    end
  end
endmodule

// File: tb/tb_pipe_stage_hs.sv
// tb_pipe_stage_hs: directed vector table plus randomised queue-model run for pipe_stage_hs
module tb_pipe_stage_hs;
`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, rdy, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [1:0] occ;
  int n_pass = 0;
  int n_tot = 0;
  always #5 clk = ~clk;
  pipe_stage_hs #(.DATA_W(32), .RST_DATA(32'h0), .FLUSH_CLR(1'b1)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .occ(occ)
  );
  typedef struct {
    logic rst, rdy, flush, iv, ordy;
    logic [31:0] din;
    logic e_ir, e_ov;
    logic [31:0] e_od;
    logic [1:0] e_occ;
  } vec_t;
  vec_t tbl[$];
  logic [31:0] q[$];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endtask
  function automatic vec_t v(input logic r, input logic e, input logic f, input logic iv, input logic ordy,
                             input logic [31:0] din, input logic ir, input logic ov, input logic [31:0] od,
                             input logic [1:0] oc);
    vec_t t;
    t.rst = r; t.rdy = e; t.flush = f; t.iv = iv; t.ordy = ordy; t.din = din;
    t.e_ir = ir; t.e_ov = ov; t.e_od = od; t.e_occ = oc;
    return t;
  endfunction
  initial begin
    logic [1:0] full;
    logic e_ir;
    full = SKID ? 2'd2 : 2'd1;
    // reset, then a back-to-back stream
    tbl.push_back(v(1, 1, 0, 1, 1, 32'h11, 0, 0, 32'h0, 0));
    tbl.push_back(v(1, 1, 0, 1, 1, 32'h11, 0, 0, 32'h0, 0));
    tbl.push_back(v(0, 1, 0, 0, 1, 32'h0, 1, 0, 32'h0, 0));
    tbl.push_back(v(0, 1, 0, 1, 1, 32'h11, 1, 1, 32'h11, 1));
    tbl.push_back(v(0, 1, 0, 1, 1, 32'h22, 1, 1, 32'h22, 1));
    tbl.push_back(v(0, 1, 0, 1, 1, 32'h33, 1, 1, 32'h33, 1));
    tbl.push_back(v(0, 1, 0, 0, 1, 32'h0, 1, 0, 32'h33, 0));
    // downstream stall with a second payload pending
    tbl.push_back(v(0, 1, 0, 1, 0, 32'hAA, 1, 1, 32'hAA, 1));
    tbl.push_back(v(0, 1, 0, 1, 0, 32'hBB, SKID, 1, 32'hAA, full));
    tbl.push_back(v(0, 1, 0, 1, 0, 32'hBB, 0, 1, 32'hAA, full));
    tbl.push_back(v(0, 1, 0, 1, 1, 32'hBB, !SKID, 1, 32'hBB, 1));
    tbl.push_back(v(0, 1, 0, 0, 1, 32'h0, 1, 0, 32'hBB, 0));
    // rdy freeze for three cycles
    tbl.push_back(v(0, 1, 0, 1, 1, 32'h55, 1, 1, 32'h55, 1));
    tbl.push_back(v(0, 0, 0, 1, 1, 32'h66, 0, 1, 32'h55, 1));
    tbl.push_back(v(0, 0, 0, 1, 1, 32'h66, 0, 1, 32'h55, 1));
    tbl.push_back(v(0, 0, 0, 1, 1, 32'h66, 0, 1, 32'h55, 1));
    tbl.push_back(v(0, 1, 0, 0, 1, 32'h0, 1, 0, 32'h55, 0));
    // flush while full with a same-cycle push
    tbl.push_back(v(0, 1, 0, 1, 0, 32'h70, 1, 1, 32'h70, 1));
    tbl.push_back(v(0, 1, 0, 1, 0, 32'h71, SKID, 1, 32'h70, full));
    tbl.push_back(v(0, 1, 1, 1, 0, 32'h77, 0, 0, 32'h0, 0));
    tbl.push_back(v(0, 1, 0, 0, 1, 32'h0, 1, 0, 32'h0, 0));
    // priorities: !rdy over flush, rst over !rdy
    tbl.push_back(v(0, 1, 0, 1, 0, 32'h99, 1, 1, 32'h99, 1));
    tbl.push_back(v(0, 0, 1, 1, 0, 32'hA0, 0, 1, 32'h99, 1));
    tbl.push_back(v(0, 1, 1, 1, 1, 32'hA1, 0, 0, 32'h0, 0));
    tbl.push_back(v(0, 1, 0, 1, 0, 32'h12, 1, 1, 32'h12, 1));
    tbl.push_back(v(1, 0, 0, 1, 1, 32'h13, 0, 0, 32'h0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 32'h0, 1, 0, 32'h0, 0));
    foreach (tbl[i]) begin
      rst = tbl[i].rst; rdy = tbl[i].rdy; flush = tbl[i].flush;
      in_valid = tbl[i].iv; out_ready = tbl[i].ordy; in_data = tbl[i].din;
      #1;
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
      @(posedge clk); #1;
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("v%0d out_data", i), out_data, tbl[i].e_od);
      chk($sformatf("v%0d occ", i), 32'(occ), 32'(tbl[i].e_occ));
    end
    // random handshake traffic against an in-order queue model
    for (int c = 0; c < 3000; c++) begin
      rst = 1'b0;
      rdy = $urandom_range(9) != 0;
      flush = $urandom_range(19) == 0;
      in_valid = $urandom_range(4) < 3;
      out_ready = $urandom_range(4) < 3;
      in_data = $urandom;
      #1;
      e_ir = rdy && !flush && (SKID ? (q.size() < 2) : (q.size() == 0 || out_ready));
      chk($sformatf("r%0d in_ready", c), 32'(in_ready), 32'(e_ir));
      chk($sformatf("r%0d out_valid", c), 32'(out_valid), 32'(q.size() > 0));
      chk($sformatf("r%0d occ", c), 32'(occ), 32'(q.size()));
      if (q.size() > 0) chk($sformatf("r%0d out_data", c), out_data, q[0]);
      if (rdy) begin
        if (flush) q.delete();
        else begin
          if (q.size() > 0 && out_ready) void'(q.pop_front());
          if (in_valid && e_ir) q.push_back(in_data);
        end
      end
      @(posedge clk); #1;
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
